// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// mem_bus_arbiter
// Shares one 32-bit memory bus between the instruction-fetch port (I) and
// the data port (D). One transaction at a time goes through a registered
// IDLE -> BUSY_x -> IDLE handshake, guarded by a timeout watchdog.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   i_req/i_addr             fetch request (read only)
//   i_rdata/i_ack/i_err      fetch result, one-cycle ack, timeout flag
//   d_req/d_we/d_sel/d_addr/d_wdata   data request
//   d_rdata/d_ack/d_err      data result, one-cycle ack, timeout flag
//   m_req/m_we/m_sel/m_addr/m_wdata   registered bus request to memory
//   m_rdata/m_ack            bus read data and single-cycle acknowledge
//   stallreq_if/stallreq_mem pipeline stall requests to ctrl
module mem_bus_arbiter #(
    parameter int PRIORITY_MODE  = 0,    // 0 = round-robin, 1 = D always wins
    parameter int TIMEOUT_CYCLES = 255,  // BUSY cycles without m_ack before abort
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_sel,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        stallreq_if,
    output logic        stallreq_mem
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_d;   // last grant: 0 = I, 1 = D

    // D wins when alone, under fixed priority, or when I was served last.
    logic w_grant_d;
    assign w_grant_d = d_req & (~i_req | (PRIORITY_MODE != 0) | ~r_last_d);

    assign stallreq_if  = i_req & ~i_ack;
    assign stallreq_mem = d_req & ~d_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_last_d <= 1'b0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_sel    <= 4'h0;
            m_addr   <= '0;
            m_wdata  <= '0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
            i_err    <= 1'b0;
            d_err    <= 1'b0;
        end else begin
            // acks and error flags are single-cycle pulses
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            i_err <= 1'b0;
            d_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    // m_ack seen here is stray and deliberately ignored
                    if (w_grant_d) begin
                        r_state  <= BUSY_D;
                        m_req    <= 1'b1;
                        m_we     <= d_we;
                        m_sel    <= d_sel;
                        m_addr   <= d_addr;
                        m_wdata  <= d_wdata;
                        r_last_d <= 1'b1;
                        r_cnt    <= '0;
                    end else if (i_req) begin
                        r_state  <= BUSY_I;
                        m_req    <= 1'b1;
                        m_we     <= 1'b0;
                        m_sel    <= 4'hF;
                        m_addr   <= i_addr;
                        r_last_d <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // ack is tested first so it wins over a same-cycle timeout
                    if (m_ack) begin
                        m_req   <= 1'b0;
                        r_state <= IDLE;
                        if (r_state == BUSY_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= m_rdata;
                        end else begin
                            d_ack <= 1'b1;
                            if (!m_we) d_rdata <= m_rdata;
                        end
                    end else if (r_cnt == TO_LAST) begin
                        m_req   <= 1'b0;
                        r_state <= IDLE;
                        if (r_state == BUSY_I) begin
                            i_ack   <= 1'b1;
                            i_err   <= 1'b1;
                            i_rdata <= '0;
                        end else begin
                            d_ack   <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
